// File: rtl/fifo_pkg.sv
// Shared helpers for the parametrised sync FIFO: width calculations and read-mode encoding.
package fifo_pkg;

  typedef enum logic {
    REG_READ  = 1'b0,
    FWFT_READ = 1'b1
  } read_mode_e;

  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

  // Count needs one extra bit so that "completely full" (== depth) is representable.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/param_sync_fifo_if.sv
// Producer/consumer bundle for param_sync_fifo; max_count exists only with FIFO_WATERMARK_EN.
interface param_sync_fifo_if
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int CNT_W      = cnt_width(DEPTH)
);
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_en;
  logic                  rd_en;
  logic [CNT_W-1:0]      af_thresh;
  logic [CNT_W-1:0]      ae_thresh;
  logic                  err_clr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [CNT_W-1:0]      count;
  logic                  overflow;
  logic                  underflow;
`ifdef FIFO_WATERMARK_EN
  logic [CNT_W-1:0]      max_count;

  modport master (
    output wr_data, wr_en, rd_en, af_thresh, ae_thresh, err_clr,
    input  rd_data, full, empty, almost_full, almost_empty, count,
           overflow, underflow, max_count
  );
  modport slave (
    input  wr_data, wr_en, rd_en, af_thresh, ae_thresh, err_clr,
    output rd_data, full, empty, almost_full, almost_empty, count,
           overflow, underflow, max_count
  );
`else
  modport master (
    output wr_data, wr_en, rd_en, af_thresh, ae_thresh, err_clr,
    input  rd_data, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );
  modport slave (
    input  wr_data, wr_en, rd_en, af_thresh, ae_thresh, err_clr,
    output rd_data, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );
`endif
endinterface

// File: rtl/fifo_mem.sv
// Storage array for param_sync_fifo: one synchronous write port, one asynchronous read port.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  localparam int ADDR_W    = ptr_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with registered or fall-through read, programmable almost flags and sticky errors.
// Optional FIFO_WATERMARK_EN adds a peak-occupancy register (max_count).
module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int FWFT       = 0,
  parameter int CNT_W      = cnt_width(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  param_sync_fifo_if.slave     bus
);

  localparam int PTR_W = ptr_width(DEPTH);

  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count, count_nxt;
  logic [DATA_WIDTH-1:0] head;
  logic [DATA_WIDTH-1:0] rd_q;
  logic                  full, empty;
  logic                  wr_acc, rd_acc;
  logic                  ovf_evt, unf_evt;
  logic                  overflow, underflow;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign rd_acc  = bus.rd_en && !empty;
  // A full FIFO still accepts a write when the same cycle frees a slot.
  assign wr_acc  = bus.wr_en && (!full || rd_acc);
  assign ovf_evt = bus.wr_en && full && !rd_acc;
  assign unf_evt = bus.rd_en && empty;

  always_comb begin
    count_nxt = count;
    if (wr_acc && !rd_acc)      count_nxt = count + CNT_W'(1);
    else if (!wr_acc && rd_acc) count_nxt = count - CNT_W'(1);
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc && rst_n),
    .waddr (wr_ptr),
    .wdata (bus.wr_data),
    .raddr (rd_ptr),
    .rdata (head)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_acc) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_nxt;
      // A new error in the clearing cycle must not be lost, so set beats clear.
      if (ovf_evt)          overflow <= 1'b1;
      else if (bus.err_clr) overflow <= 1'b0;
      if (unf_evt)          underflow <= 1'b1;
      else if (bus.err_clr) underflow <= 1'b0;
    end
  end

  generate
    if (FWFT == int'(FWFT_READ)) begin : g_fwft
      // Head is shown directly; zero while empty keeps the idle bus quiet.
      assign rd_q = empty ? '0 : head;
    end else begin : g_reg
      always_ff @(posedge clk) begin
        if (!rst_n)      rd_q <= '0;
        else if (rd_acc) rd_q <= head;
      end
    end
  endgenerate

`ifdef FIFO_WATERMARK_EN
  logic [CNT_W-1:0] max_count;

  always_ff @(posedge clk) begin
    if (!rst_n)                   max_count <= '0;
    else if (bus.err_clr)         max_count <= count_nxt;
    else if (count_nxt > max_count) max_count <= count_nxt;
  end

  assign bus.max_count = max_count;
`endif

  assign bus.rd_data      = rd_q;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (bus.af_thresh != '0) && (count >= bus.af_thresh);
  assign bus.almost_empty = (count <= bus.ae_thresh);
  assign bus.count        = count;
  assign bus.overflow     = overflow;
  assign bus.underflow    = underflow;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Drives a registered-read and a fall-through FIFO with identical stimulus against a queue model.
module tb_param_sync_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int CW    = 5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  param_sync_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus0 ();
  param_sync_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus1 ();

  param_sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(0)) u_reg (
    .clk (clk), .rst_n (rst_n), .bus (bus0.slave)
  );
  param_sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1)) u_fwft (
    .clk (clk), .rst_n (rst_n), .bus (bus1.slave)
  );

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] q[$];
  logic [DW-1:0] exp_rd;
  bit            exp_ovf, exp_unf;
  int            exp_max;
  int            af_v, ae_v;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic verify();
    int n;
    n = q.size();
    check("count",        32'(bus0.count), 32'(n));
    check("empty",        32'(bus0.empty), 32'(n == 0));
    check("full",         32'(bus0.full), 32'(n == DEPTH));
    check("almost_full",  32'(bus0.almost_full), 32'((af_v != 0) && (n >= af_v)));
    check("almost_empty", 32'(bus0.almost_empty), 32'(n <= ae_v));
    check("overflow",     32'(bus0.overflow), 32'(exp_ovf));
    check("underflow",    32'(bus0.underflow), 32'(exp_unf));
    check("rd_data_reg",  32'(bus0.rd_data), 32'(exp_rd));
    check("count_fwft",   32'(bus1.count), 32'(n));
    check("ovf_fwft",     32'(bus1.overflow), 32'(exp_ovf));
    if (n > 0) check("rd_data_fwft", 32'(bus1.rd_data), 32'(q[0]));
`ifdef FIFO_WATERMARK_EN
    check("max_count",    32'(bus0.max_count), 32'(exp_max));
`endif
  endtask

  // One clock: apply inputs, advance the model by the rules of the block, then compare.
  task automatic step(input bit we, input logic [DW-1:0] wd, input bit re,
                      input bit clr = 1'b0, input bit rn = 1'b1);
    int  n;
    bit  rd_ok, wr_ok;
    rst_n = rn;
    bus0.wr_en = we; bus0.wr_data = wd; bus0.rd_en = re; bus0.err_clr = clr;
    bus1.wr_en = we; bus1.wr_data = wd; bus1.rd_en = re; bus1.err_clr = clr;
    bus0.af_thresh = CW'(af_v); bus0.ae_thresh = CW'(ae_v);
    bus1.af_thresh = CW'(af_v); bus1.ae_thresh = CW'(ae_v);
    @(posedge clk);
    if (!rn) begin
      q.delete();
      exp_rd = '0; exp_ovf = 0; exp_unf = 0; exp_max = 0;
    end else begin
      n     = q.size();
      rd_ok = re && (n > 0);
      wr_ok = we && ((n < DEPTH) || rd_ok);
      if (we && (n == DEPTH) && !rd_ok) exp_ovf = 1;
      else if (clr)                     exp_ovf = 0;
      if (re && (n == 0)) exp_unf = 1;
      else if (clr)       exp_unf = 0;
      if (rd_ok) exp_rd = q.pop_front();
      if (wr_ok) q.push_back(wd);
      if (clr)                      exp_max = q.size();
      else if (q.size() > exp_max)  exp_max = q.size();
    end
    #1;
    verify();
  endtask

  initial begin
    af_v = 0; ae_v = 0;
    exp_rd = '0; exp_ovf = 0; exp_unf = 0; exp_max = 0;
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    // Fill 0..15, overflow once, then drain in order with af disabled.
    for (int i = 0; i < DEPTH; i++) step(1, DW'(i), 0);
    step(1, 8'hEE, 0);
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 0, 1);
      check("t1_order", 32'(bus0.rd_data), 32'(i));
    end
    step(0, 0, 0, 1);

    // Fall-through visibility of a single word.
    step(1, 8'hA5, 0);
    check("t2_fwft_a5", 32'(bus1.rd_data), 32'hA5);
    step(0, 0, 1);
    check("t2_reg_a5", 32'(bus0.rd_data), 32'hA5);

    // Full with simultaneous read+write: count holds, no overflow.
    for (int i = 0; i < DEPTH; i++) step(1, DW'(8'h10 + i), 0);
    for (int i = 0; i < 10; i++) step(1, DW'(8'h50 + i), 1);
    for (int i = 0; i < DEPTH; i++) step(0, 0, 1);

    // Threshold edges while filling and draining.
    af_v = 12; ae_v = 3;
    for (int i = 0; i < DEPTH; i++) step(1, DW'($urandom_range(0, 255)), 0);
    af_v = 0;
    step(0, 0, 0);
    af_v = 12;
    for (int i = 0; i < DEPTH; i++) step(0, 0, 1);

    // Underflow, clear, and error coinciding with clear.
    step(0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 1, 1);
    step(1, 8'h33, 1);
    step(0, 0, 0, 1);

    // Mid-stream reset discards contents and flags.
    for (int i = 0; i < 5; i++) step(1, DW'(8'hC0 + i), 0);
    step(0, 0, 1);
    step(1, 8'h77, 1, 0, 0);
    check("t6_rd_zero", 32'(bus0.rd_data), 32'h0);
    for (int i = 0; i < DEPTH; i++) step(1, DW'(i), 0);
    step(1, 8'h99, 0, 1);
    step(0, 0, 1, 1);

    // Randomised traffic with phase bias to reach both full and empty.
    for (int i = 0; i < 600; i++) begin
      int wp;
      wp = ((i / 60) % 2 == 0) ? 75 : 25;
      if (i % 97 == 0) begin
        af_v = $urandom_range(0, DEPTH);
        ae_v = $urandom_range(0, DEPTH);
      end
      step($urandom_range(0, 99) < wp, DW'($urandom_range(0, 255)),
           $urandom_range(0, 99) < (100 - wp),
           $urandom_range(0, 29) == 0,
           $urandom_range(0, 249) != 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/param_sync_fifo.md
Name: param_sync_fifo

Overview:
Next-generation single-clock FIFO that replaces the fixed 8x16 sync FIFO. Data width and depth are parametrised. It adds a compile-time read mode: registered read or first-word-fall-through (FWFT). Almost-full/almost-empty thresholds are runtime-programmable, and sticky overflow/underflow error flags are provided. It sits between producer and consumer blocks in the same clock domain.

Parameters:
DATA_WIDTH, 8, width of each entry in bits (>=1)
DEPTH, 16, number of entries; power of two, >=2
FWFT, 0, 0 = registered read (data one cycle after pop); 1 = first-word-fall-through
CNT_W, $clog2(DEPTH)+1, width of count and threshold ports (derived; do not override)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
wr_data  in  DATA_WIDTH  write data
wr_en  in  1  write request
rd_en  in  1  read/pop request
af_thresh  in  CNT_W  almost_full threshold; 0 = disabled
ae_thresh  in  CNT_W  almost_empty threshold
err_clr  in  1  clears the sticky error flags (and the watermark, if present)
rd_data  out  DATA_WIDTH  read data
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  (af_thresh != 0) && (count >= af_thresh)
almost_empty  out  1  count <= ae_thresh
count  out  CNT_W  current occupancy, 0..DEPTH
overflow  out  1  sticky: a write was dropped
underflow  out  1  sticky: a read was rejected

Behaviour:
- Reset (rst_n low at a rising clk edge): pointers=0, count=0, rd_data=0, overflow=0, underflow=0. Consequently empty=1, full=0, almost_full=0, almost_empty=1. Memory contents are not reset.
- Accepted write: wr_en && (!full || rd_accept). Accepted read (rd_accept): rd_en && !empty.
- Writing into a full FIFO with a simultaneous accepted read is accepted; count is unchanged.
- Reading an empty FIFO with a simultaneous write: the read is rejected and the write is accepted; the new word is not bypassed.
- count: +1 on write only, -1 on read only, unchanged on both or neither. Updated on the same edge as the pointers. full, empty, almost_full and almost_empty are combinational from count and the threshold ports.
- Pointers are log2(DEPTH) bits and wrap naturally modulo DEPTH.
- FWFT=0: on an accepted read, rd_data is loaded with the head entry at that edge, so data is valid the cycle after rd_en. rd_data holds its value otherwise.
- FWFT=1: rd_data always shows the head entry while !empty; rd_en pops it. Data is visible in the cycle after the write edge that makes the FIFO non-empty. rd_data is don't-care while empty.
- overflow sets when wr_en && full && no accepted read. underflow sets when rd_en && empty. Both stay set until err_clr or reset. If err_clr coincides with a new error event, the set wins.
- A dropped write or rejected read has no effect on data, pointers or count.
- Reset asserted mid-stream discards all contents on that edge. Operations in the reset cycle are ignored.

Optional Feature:
FIFO_WATERMARK_EN
- Defined: adds output max_count [CNT_W]. max_count is a register holding the peak count since reset or since the last err_clr. Reset to 0. It updates to the new count whenever the post-edge count exceeds it. On err_clr it loads the current post-edge count.
- Undefined: the max_count port and its register do not exist. All other behaviour is identical.

Decomposition:
- Package fifo_pkg holds:
  - the CNT_W / pointer-width calculation function (clog2-based);
  - a read_mode_e typedef (REG_READ=0, FWFT_READ=1) for use by instantiating blocks.
- One sub-module: fifo_mem, a simple dual-port register array (one write port, one asynchronous read port) parametrised by DATA_WIDTH and DEPTH.
- Control, count, flags and rd_data register stay in param_sync_fifo.

Test Plan:
1. DEPTH=16, FWFT=0: write 0..15 -> full=1, count=16. One more write -> overflow=1, count stays 16. Read 16 -> rd_data 0..15 in order, each valid the cycle after rd_en; then empty=1.
2. FWFT=1: write 0xA5 into the empty FIFO -> rd_data=0xA5 the next cycle with no rd_en. Pop -> empty=1, count=0.
3. Fill to 16, then hold wr_en and rd_en for 10 cycles writing 0x50+i -> count stays 16, no overflow. Drain -> 6 old words, then 0x50..0x59.
4. af_thresh=12, ae_thresh=3: fill from 0 -> almost_empty drops when count goes 3->4; almost_full rises when count reaches 12. With af_thresh=0, almost_full stays 0 at count=16.
5. rd_en on empty -> underflow=1, count=0. Pulse err_clr -> underflow=0. Error event coinciding with err_clr -> flag remains 1.
6. Write 5 words, assert rst_n low for one edge -> count=0, empty=1, rd_data=0, flags=0. With FIFO_WATERMARK_EN defined, max_count peaks at 16 after a fill and err_clr reloads it with the current count.
